// File: rtl/bitwise_pipe.sv
// Two-stage bitwise ALU pipeline with valid/ready handshake on both sides.
// S1 holds the accepted operands, S2 holds the registered result. A
// free-running transfer counter tallies completed output handshakes.

// One result bit: the op decode applied to a single bit position.
module bitwise_lane (
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);

    // Bitwise op decode; each lane only sees its own bit, so no carries exist.
    always_comb begin
        y = 1'b0;
        case (op)
            3'b000:  y = ~a;
            3'b001:  y = a & b;
            3'b010:  y = a | b;
            3'b011:  y = a ^ b;
            3'b100:  y = ~(a & b);
            3'b101:  y = ~(a | b);
            3'b110:  y = ~(a ^ b);
            default: y = a;
        endcase
    end

endmodule

module bitwise_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [CNT_W-1:0] xfer_cnt
);

    // S1 operand register; data is only written on accept, so it goes stale
    // (but harmless) whenever s1_valid is low.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } req_t;

    req_t             s1_req;
    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_zero;
    logic [WIDTH-1:0] res;
    logic             s2_free;
    logic             s1_move;
    logic             accept;

    // S2 can take a new result if it is empty or being drained this cycle.
    assign s2_free  = !s2_valid || out_ready;
    assign s1_move  = s1_valid && s2_free;
    // Combinational from out_ready so a full pipe can drain and refill in one cycle.
    assign in_ready = !reset && (!s1_valid || s2_free);
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        bitwise_lane u_lane (
            .a  (s1_req.a[g]),
            .b  (s1_req.b[g]),
            .op (s1_req.op),
            .y  (res[g])
        );
    end

    // S1: capture operands on accept, empty when the item moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_req   <= '{a: a, b: b, op: op};
            s1_valid <= 1'b1;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: register the result; hold it while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_zero  <= 1'b0;
        end else if (s1_move) begin
            s2_valid <= 1'b1;
            s2_y     <= res;
            s2_zero  <= (res == '0);
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Completed output handshakes; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (s2_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

    assign out_valid = s2_valid;
    assign y         = s2_y;
    assign zero      = s2_zero && s2_valid;

endmodule

// File: tb/tb_bitwise_pipe.sv
// Directed bench for bitwise_pipe: a WIDTH=4/CNT_W=2 instance for the
// hand-computed vectors and counter wrap, and a WIDTH=8 instance for a
// random valid/ready stream checked against a reference queue.
module tb_bitwise_pipe;

    logic       clk = 1'b0;
    logic       reset;

    logic       in_valid, in_ready, out_valid, out_ready, zero;
    logic [3:0] a, b, y;
    logic [2:0] op;
    logic [1:0] xfer_cnt;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, zero8;
    logic [7:0] a8, b8, y8;
    logic [2:0] op8;
    logic [7:0] xfer_cnt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitwise_pipe #(.WIDTH(4), .CNT_W(2)) u4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .xfer_cnt(xfer_cnt)
    );

    bitwise_pipe #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .zero(zero8), .xfer_cnt(xfer_cnt8)
    );

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] z,
                                          input logic [2:0] o);
        case (o)
            3'b000:  return ~x;
            3'b001:  return x & z;
            3'b010:  return x | z;
            3'b011:  return x ^ z;
            3'b100:  return ~(x & z);
            3'b101:  return ~(x | z);
            3'b110:  return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    // Leaves the bench at a negedge with reset low and both pipes empty.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; a = 4'b0101; b = 4'b0; op = 3'b000; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || y !== 4'b0 || zero !== 1'b0 || xfer_cnt !== 2'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b y=%b zero=%b cnt=%0d in_ready=%b, want 0 0000 0 0 0",
                     out_valid, y, zero, xfer_cnt, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_accept: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || y !== 4'b1010) begin
            errors++;
            $display("FAIL reset_first_result: out_valid=%b y=%b, want 1 1010", out_valid, y);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        logic [3:0] idx;
        do_reset();
        out_ready = 1'b1; op = 3'b000; b = 4'b0; in_valid = 1'b1; a = 4'd0;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            checks++;
            if (cyc == 1) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL exh_latency: out_valid=%b, want 0", out_valid);
                end
            end else begin
                idx = 4'(cyc - 2);
                if (out_valid !== 1'b1 || y !== ~idx || zero !== (idx == 4'hf) || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL exh_a%0d: out_valid=%b y=%b zero=%b in_ready=%b, want 1 %b %b 1",
                             idx, out_valid, y, zero, in_ready, ~idx, (idx == 4'hf));
                end
            end
            if (cyc < 16) a = 4'(cyc);
            else in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_all_ops();
        logic [3:0] exp_y [8];
        exp_y = '{4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100};
        do_reset();
        out_ready = 1'b1; a = 4'b1100; b = 4'b1010; op = 3'd0; in_valid = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || y !== exp_y[cyc-2] || zero !== 1'b0) begin
                    errors++;
                    $display("FAIL op%0d: out_valid=%b y=%b zero=%b, want 1 %b 0",
                             cyc - 2, out_valid, y, zero, exp_y[cyc-2]);
                end
            end
            if (cyc < 8) op = 3'(cyc);
            else in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; op = 3'b111; b = 4'b0; in_valid = 1'b1; a = 4'd1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after1: in_ready=%b, want 1", in_ready);
        end
        a = 4'd2;
        @(negedge clk);
        a = 4'd3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 4'd1) begin
                errors++;
                $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b y=%0d, want 0 1 1",
                         i, in_ready, out_valid, y);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; a = 4'd9;
        for (int i = 2; i <= 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || y !== 4'(i)) begin
                errors++;
                $display("FAIL bp_drain%0d: out_valid=%b y=%0d, want 1 %0d", i, out_valid, y, i);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 2'd3) begin
            errors++;
            $display("FAIL bp_count: out_valid=%b cnt=%0d, want 0 3", out_valid, xfer_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0; op = 3'b111; in_valid = 1'b1; a = 4'd5;
        @(negedge clk);
        a = 4'd6;
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || y !== 4'd0 || xfer_cnt !== 2'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: out_valid=%b y=%0d cnt=%0d in_ready=%b, want 0 0 0 0",
                     out_valid, y, xfer_cnt, in_ready);
        end
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_ghost%0d: out_valid=%b y=%0d, want 0", i, out_valid, y);
            end
        end
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        out_ready = 1'b1; op = 3'b111; in_valid = 1'b1; a = 4'd0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc >= 3 && cyc <= 7) begin
                checks++;
                if (xfer_cnt !== exp_cnt[cyc-3]) begin
                    errors++;
                    $display("FAIL cnt_wrap%0d: cnt=%0d, want %0d", cyc - 3, xfer_cnt, exp_cnt[cyc-3]);
                end
            end
            if (cyc < 5) a = 4'(cyc);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] e;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        do_reset();
        while (got < 1000 && cyc < 20000) begin
            in_valid8  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a8         = 8'($urandom);
            b8         = 8'($urandom);
            op8        = 3'($urandom);
            out_ready8 = 1'($urandom_range(0, 1));
            #1;
            if (out_valid8 && out_ready8) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: y=%h with empty reference queue", y8);
                end else begin
                    e = q.pop_front();
                    if (y8 !== e || zero8 !== (e == 8'h0)) begin
                        errors++;
                        $display("FAIL rnd_item%0d: y=%h zero=%b, want %h %b", got, y8, zero8, e, (e == 8'h0));
                    end
                end
                got++;
            end
            if (in_valid8 && in_ready8) begin
                q.push_back(ref_op(a8, b8, op8));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid8 = 1'b0;
        checks++;
        if (got != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL rnd_total: received=%0d pending=%0d, want 1000 0", got, q.size());
        end
    endtask

    initial begin
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
        test_reset();
        test_exhaustive();
        test_all_ops();
        test_backpressure();
        test_reset_midstream();
        test_cnt_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
